logo_bounce_ctrl: RTL and testbench
===================================

Name: logo_bounce_ctrl

Overview:
- Frame-rate motion controller directly upstream of the VGA pixel/colour stage.
- Watches `vsync` from the sync generator and keeps a 128x128 logo's top-left position, moving it by a programmable step once per frame and bouncing it off the screen edges.
- From the live `pix_x`/`pix_y` beam position it produces the logo-relative bitmap ROM address (`rel_x`, `rel_y`) and an `in_logo` window flag.
- Produces a palette index that advances on every bounce; this replaces the constant palette index currently used by the pixel stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- LOGO_W, 128, logo width in pixels (power of two, at most 128).
- LOGO_H, 128, logo height in lines (power of two, at most 128).
- VSYNC_ACT, 0, active level of the `vsync` input (0 = active-low).

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- vsync  input  1  vertical sync from the sync generator.
- pix_x  input  10  current beam column.
- pix_y  input  10  current beam row.
- enable  input  1  1 = motion enabled; 0 = freeze position and colour.
- speed  input  2  step per frame = speed+1 pixels (1..4).
- logo_x  output  10  registered top-left column of the logo.
- logo_y  output  10  registered top-left row of the logo.
- rel_x  output  7  `pix_x - logo_x`, truncated to 7 bits (ROM x address).
- rel_y  output  7  `pix_y - logo_y`, truncated to 7 bits (ROM y address).
- in_logo  output  1  beam is inside the logo window.
- color_index  output  3  palette index for the pixel stage, never 0.
- frame_tick  output  1  one-cycle pulse at the start of each vsync.
- bounce  output  1  one-cycle pulse, coincident with `frame_tick`, when any edge was hit.

Behaviour:
- Reset is synchronous and active-high; while `reset` = 1 at a clock edge:
  - `logo_x` = 0, `logo_y` = 0.
  - dir_x = +, dir_y = + (internal direction bits).
  - `color_index` = 7.
  - `frame_tick` = 0, `bounce` = 0.
  - vsync_q = inactive level (`~VSYNC_ACT`).
- vsync_q registers `vsync` every cycle. `frame_tick` is registered: it is 1 for exactly the one cycle after `vsync` = VSYNC_ACT and vsync_q != VSYNC_ACT. This gives exactly one tick per frame, and no tick when `vsync` is already active as reset is released.
- Position update occurs in the same cycle `frame_tick` is set, and only if `enable` = 1. It lands inside vertical blanking, so there is no tearing. step = `speed`+1; the arithmetic is 11 bits wide, so there is no wrap.
- X axis (Y axis identical, using `logo_y`, V_ACTIVE, LOGO_H, dir_y); XMAX = H_ACTIVE-LOGO_W (512 by default):
  - dir_x = + and `logo_x`+step >= XMAX: `logo_x` <= XMAX, dir_x <= −, hit_x = 1.
  - dir_x = + otherwise: `logo_x` <= `logo_x`+step.
  - dir_x = − and `logo_x` <= step: `logo_x` <= 0, dir_x <= +, hit_x = 1.
  - dir_x = − otherwise: `logo_x` <= `logo_x`−step.
- Position never leaves [0, XMAX] × [0, YMAX]. Landing exactly on an edge counts as a hit.
- Bounce and colour:
  - `bounce` = hit_x | hit_y, asserted the same cycle as `frame_tick`.
  - On a bounce, `color_index` advances once, even on a corner (both axes hit): 1→2→…→7→1. 0 is never produced.
- `enable` = 0:
  - `frame_tick` still pulses.
  - Position, direction and `color_index` hold, and `bounce` stays 0.
  - Changes to `speed` take effect at the next tick.
- Window outputs are combinational from `pix_x`/`pix_y` and the registered position, with zero latency:
  - `in_logo` = (`pix_x` >= `logo_x`) & (`pix_x` < `logo_x`+LOGO_W) & (`pix_y` >= `logo_y`) & (`pix_y` < `logo_y`+LOGO_H).
  - `rel_x`/`rel_y` are always driven; they are meaningful only when `in_logo` = 1.
- Downstream timing: the pixel stage registers RGB one cycle after sampling these outputs, as it does today.
- Reset mid-frame: the position returns to 0,0 on the next edge and the first tick occurs at the next vsync assertion.

Test Plan:
- Reset, then run 3 frames with `speed` = 0 and `enable` = 1 -> `logo_x`/`logo_y` = 1,2,3; one `frame_tick` per vsync assertion; `bounce` = 0; `color_index` = 7.
- Preload to `logo_x` = 510, dir + (run frames), `speed` = 3 -> next tick `logo_x` = 512, dir flips, `bounce` = 1, `color_index` 7→1; following tick `logo_x` = 508.
- Drive position to a corner (`logo_x` = 511, `logo_y` = 351, `speed` = 0, both dirs +) -> one tick gives 512/352, both dirs flip, a single `bounce`, `color_index` +1 only.
- `enable` = 0 for 5 frames -> 5 `frame_tick` pulses; `logo_x`, `logo_y` and `color_index` unchanged; `bounce` never asserted.
- With `logo_x` = 100, `logo_y` = 40, sweep `pix_x` 99/100/227/228 on `pix_y` = 40 -> `in_logo` = 0/1/1/0; `rel_x` = 0 at 100 and 127 at 227; `rel_y` = 0.
- Assert `reset` one cycle mid-line while `vsync` is active -> all outputs return to reset values next edge; no `frame_tick` until `vsync` goes inactive and then active again.

Source files
------------

// File: rtl/logo_bounce_ctrl.sv
// logo_bounce_ctrl: frame-rate bouncing logo position, beam window decode and bounce palette index
module logo_bounce_ctrl #(
    parameter int   H_ACTIVE  = 640,
    parameter int   V_ACTIVE  = 480,
    parameter int   LOGO_W    = 128,
    parameter int   LOGO_H    = 128,
    parameter logic VSYNC_ACT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       enable,
    input  logic [1:0] speed,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic [6:0] rel_x,
    output logic [6:0] rel_y,
    output logic       in_logo,
    output logic [2:0] color_index,
    output logic       frame_tick,
    output logic       bounce
);
    localparam logic [10:0] XMAX = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] YMAX = 11'(V_ACTIVE - LOGO_H);

    logic        vsync_q, vsync_seen, dir_x, dir_y, tick, hit_x, hit_y;
    logic [10:0] step, x_inc, y_inc, x_end, y_end;
    logic [9:0]  nx, ny;

    // vsync_seen blocks a tick until vsync has been observed inactive after reset
    assign tick  = vsync_seen && (vsync == VSYNC_ACT) && (vsync_q != VSYNC_ACT);
    assign step  = {9'd0, speed} + 11'd1;
    assign x_inc = {1'b0, logo_x} + step;
    assign y_inc = {1'b0, logo_y} + step;
    assign x_end = {1'b0, logo_x} + 11'(LOGO_W);
    assign y_end = {1'b0, logo_y} + 11'(LOGO_H);

    // next position per axis: clamp onto the edge and flag a hit when the step reaches it
    always_comb begin
        hit_x = dir_x ? (x_inc >= XMAX) : ({1'b0, logo_x} <= step);
        hit_y = dir_y ? (y_inc >= YMAX) : ({1'b0, logo_y} <= step);
        nx    = dir_x ? (hit_x ? XMAX[9:0] : x_inc[9:0]) : (hit_x ? 10'd0 : logo_x - step[9:0]);
        ny    = dir_y ? (hit_y ? YMAX[9:0] : y_inc[9:0]) : (hit_y ? 10'd0 : logo_y - step[9:0]);
    end

    // frame tick detection and once-per-frame motion, direction and colour update
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q     <= ~VSYNC_ACT;
            vsync_seen  <= 1'b0;
            frame_tick  <= 1'b0;
            bounce      <= 1'b0;
            logo_x      <= 10'd0;
            logo_y      <= 10'd0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            color_index <= 3'd7;
        end else begin
            vsync_q    <= vsync;
            if (vsync != VSYNC_ACT)
                vsync_seen <= 1'b1;
            frame_tick <= tick;
            bounce     <= tick && enable && (hit_x || hit_y);
            if (tick && enable) begin
                logo_x <= nx;
                logo_y <= ny;
                dir_x  <= dir_x ^ hit_x;
                dir_y  <= dir_y ^ hit_y;
                if (hit_x || hit_y)
                    color_index <= (color_index == 3'd7) ? 3'd1 : color_index + 3'd1;
            end
        end
    end

    assign in_logo = (pix_x >= logo_x) && ({1'b0, pix_x} < x_end) &&
                     (pix_y >= logo_y) && ({1'b0, pix_y} < y_end);
    assign rel_x   = 7'(pix_x - logo_x);
    assign rel_y   = 7'(pix_y - logo_y);
endmodule

// File: tb/tb_logo_bounce_ctrl.sv
// tb_logo_bounce_ctrl: directed and random frames checked against a rule-level motion model
module tb_logo_bounce_ctrl;
    logic       clk = 1'b0;
    logic       reset, vsync, enable, in_logo, frame_tick, bounce;
    logic [9:0] pix_x, pix_y, logo_x, logo_y;
    logic [1:0] speed;
    logic [6:0] rel_x, rel_y;
    logic [2:0] color_index;

    int tests = 0, fails = 0;
    int mx, my, mc, last_b, last_t;
    bit mdx, mdy, mhit;

    logo_bounce_ctrl dut (
        .clk(clk), .reset(reset), .vsync(vsync), .pix_x(pix_x), .pix_y(pix_y),
        .enable(enable), .speed(speed), .logo_x(logo_x), .logo_y(logo_y),
        .rel_x(rel_x), .rel_y(rel_y), .in_logo(in_logo), .color_index(color_index),
        .frame_tick(frame_tick), .bounce(bounce)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic axis_move(input int p, input bit d, input int lim, input int s,
                             output int np, output bit nd, output bit h);
        h  = 1'b0;
        nd = d;
        np = d ? p + s : p - s;
        if (d && p + s >= lim) begin np = lim; nd = 1'b0; h = 1'b1; end
        if (!d && p <= s) begin np = 0; nd = 1'b1; h = 1'b1; end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1'b1; mdy = 1'b1; mc = 7;
    endtask

    task automatic model_frame();
        bit hx, hy;
        int s = int'(speed) + 1;
        mhit = 1'b0;
        if (enable) begin
            axis_move(mx, mdx, 512, s, mx, mdx, hx);
            axis_move(my, mdy, 352, s, my, mdy, hy);
            mhit = hx | hy;
            if (mhit) mc = mc % 7 + 1;
        end
    endtask

    task automatic frame(input string tag);
        int t = 0, b = 0;
        for (int i = 0; i < 5; i++) begin
            vsync = (i < 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
            t += int'(frame_tick);
            b += int'(bounce);
        end
        model_frame();
        last_t = t;
        last_b = b;
        chk({tag, " ticks"}, t, 1);
        chk({tag, " bounce"}, b, int'(mhit));
        chk({tag, " logo_x"}, int'(logo_x), mx);
        chk({tag, " logo_y"}, int'(logo_y), my);
        chk({tag, " color"}, int'(color_index), mc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vsync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
    endtask

    task automatic win(input string tag, input int px, input int py);
        bit e;
        pix_x = px[9:0];
        pix_y = py[9:0];
        #1;
        e = (px >= mx) && (px < mx + 128) && (py >= my) && (py < my + 128);
        chk({tag, " in_logo"}, int'(in_logo), int'(e));
        chk({tag, " rel_x"}, int'(rel_x), (px - mx) & 127);
        chk({tag, " rel_y"}, int'(rel_y), (py - my) & 127);
    endtask

    initial begin
        int x0, y0, c0, t, ly, s, ex, ey, need, n;
        reset = 1'b0; vsync = 1'b1; enable = 1'b1; speed = 2'd0; pix_x = '0; pix_y = '0;
        @(negedge clk);
        do_reset();
        chk("reset logo_x", int'(logo_x), 0);
        chk("reset logo_y", int'(logo_y), 0);
        chk("reset color", int'(color_index), 7);
        chk("reset tick", int'(frame_tick), 0);
        chk("reset bounce", int'(bounce), 0);

        for (int i = 1; i <= 3; i++) begin
            frame("slow");
            chk("slow step", int'(logo_x), i);
        end

        win("win left-out", 2, 3);
        win("win left-in", 3, 3);
        win("win right-in", 130, 3);
        win("win right-out", 131, 3);
        win("win top-out", 3, 2);
        win("win bottom-in", 3, 130);
        win("win bottom-out", 3, 131);

        do_reset();
        speed = 2'd3;
        repeat (127) frame("run");
        speed = 2'd1;
        frame("run");
        chk("pre-edge x", int'(logo_x), 510);
        speed = 2'd3;
        c0 = mc;
        frame("edge");
        chk("edge x", int'(logo_x), 512);
        chk("edge bounce", last_b, 1);
        chk("edge color", int'(color_index), c0 % 7 + 1);
        frame("after edge");
        chk("after edge x", int'(logo_x), 508);

        enable = 1'b0;
        x0 = mx; y0 = my; c0 = mc;
        repeat (5) frame("frozen");
        chk("frozen x", int'(logo_x), x0);
        chk("frozen y", int'(logo_y), y0);
        chk("frozen color", int'(color_index), c0);
        enable = 1'b1;

        vsync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("midreset x", int'(logo_x), 0);
        chk("midreset y", int'(logo_y), 0);
        chk("midreset color", int'(color_index), 7);
        chk("midreset tick", int'(frame_tick), 0);
        chk("midreset bounce", int'(bounce), 0);
        t = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            t += int'(frame_tick);
        end
        chk("midreset no tick", t, 0);
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        frame("post reset");

        do_reset();
        t = 0; ly = 0; n = 0;
        while (t < 4607 && n < 3000) begin
            ex = mdx ? 512 - mx : mx;
            ey = mdy ? 352 - my : my;
            need = 32 - ly;
            s = (need == 0) ? imin(4, ey) : (ey <= 4) ? imin(4, ey + need) :
                (ey == 5) ? 4 : (ey <= 8) ? ey - 5 : 4;
            s = imin(imin(s, ex), 4607 - t);
            ly += (s > ey) ? s - ey : 0;
            t += s;
            n++;
            speed = 2'(s - 1);
            frame("steer");
        end
        chk("corner pre x", int'(logo_x), 511);
        chk("corner pre y", int'(logo_y), 351);
        speed = 2'd0;
        c0 = mc;
        frame("corner");
        chk("corner x", int'(logo_x), 512);
        chk("corner y", int'(logo_y), 352);
        chk("corner single bounce", last_b, 1);
        chk("corner color", int'(color_index), c0 % 7 + 1);
        frame("after corner");
        chk("after corner x", int'(logo_x), 511);
        chk("after corner y", int'(logo_y), 351);

        repeat (200) begin
            speed = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 3) != 0);
            frame("rand");
            for (int k = 0; k < 2; k++)
                win("rand win", imin(1023, mx + int'($urandom_range(0, 140))),
                    imin(1023, my + int'($urandom_range(0, 140))));
            win("rand win low", (mx > 0) ? mx - 1 : 0, my);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
